// File: rtl/fft_vis_pkg.sv
// Shared types and constants for the spectrum bus between the FFT band packer and the renderer.
package fft_vis_pkg;

   localparam int unsigned NUM_BANDS   = 16;
   localparam int unsigned BAND_WORD_W = 36;
   localparam int unsigned HEIGHT_LSB  = 18;
   localparam int unsigned HEIGHT_MSB  = 27;
   localparam int unsigned MAX_HEIGHT  = 480;

   typedef logic [BAND_WORD_W-1:0] band_word_t;

   typedef enum logic [1:0] {IDLE, ACCUM, FINAL} fsm_state_e;

   // Word layout: upper byte zero, display height, then the low bits of the raw band sum.
   function automatic band_word_t pack_band_word(input logic [9:0]  height,
                                                 input logic [17:0] sum_lo);
      band_word_t w;
      w                         = '0;
      w[HEIGHT_MSB:HEIGHT_LSB]  = height;
      w[HEIGHT_LSB-1:0]         = sum_lo;
      return w;
   endfunction

endpackage

// File: rtl/fft_mag_abs.sv
// Registered |re|+|im| magnitude; forms the first pipeline stage of the band packer.
module fft_mag_abs #(
   parameter int unsigned DATA_W = 18
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en_i,
   input  logic                     zero_i,
   input  logic signed [DATA_W-1:0] re_i,
   input  logic signed [DATA_W-1:0] im_i,
   output logic        [DATA_W:0]   mag_o
);

   logic signed [DATA_W:0] re_x, im_x;
   logic        [DATA_W:0] abs_re, abs_im, mag_d, mag_q;

   // One extra bit lets the most negative input negate without wrapping.
   always_comb begin
      re_x   = {re_i[DATA_W-1], re_i};
      im_x   = {im_i[DATA_W-1], im_i};
      abs_re = re_x[DATA_W] ? -re_x : re_x;
      abs_im = im_x[DATA_W] ? -im_x : im_x;
      mag_d  = abs_re + abs_im;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mag_q <= '0;
      end else if (en_i) begin
         mag_q <= zero_i ? '0 : mag_d;
      end
   end

   assign mag_o = mag_q;

endmodule

// File: rtl/fft_band_packer.sv
// Accumulates one streamed FFT frame into 16 display bands and publishes them on good frames.
module fft_band_packer
   import fft_vis_pkg::*;
#(
   parameter int unsigned FFT_LEN      = 256,
   parameter int unsigned DATA_W       = 18,
   parameter int unsigned HEIGHT_SHIFT = 4,
   parameter int unsigned SKIP_DC      = 1,
   parameter int unsigned FRAME_DECIM  = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     fft_valid,
   input  logic                     fft_sop,
   input  logic                     fft_eop,
   input  logic signed [DATA_W-1:0] fft_real,
   input  logic signed [DATA_W-1:0] fft_imag,
   output band_word_t               processed_fft_data [0:NUM_BANDS-1],
   output logic                     done,
   output logic [7:0]               drop_count
);

   localparam int unsigned K_W     = $clog2(FFT_LEN);
   localparam int unsigned BPB     = FFT_LEN / 32;
   localparam int unsigned BPB_LOG = $clog2(BPB);
   localparam int unsigned MAG_W   = DATA_W + 1;
   localparam int unsigned ACC_W   = MAG_W + BPB_LOG;
   localparam int unsigned DEC_W   = (FRAME_DECIM > 1) ? $clog2(FRAME_DECIM) : 1;

   localparam logic [K_W-1:0]   LAST_BIN = K_W'(FFT_LEN - 1);
   localparam logic [K_W-1:0]   HALF_BIN = K_W'(FFT_LEN / 2);
   localparam logic [ACC_W-1:0] ACC_ZERO = '0;

   fsm_state_e     state_q, state_d;
   logic [K_W-1:0] k_q, k_d, bin;
   logic [3:0]     band;
   logic           take, first, drop_inc, eop_ok;
   logic [7:0]     drop_q;

   // Next-state and beat classification
   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      bin      = k_q;
      take     = 1'b0;
      first    = 1'b0;
      drop_inc = 1'b0;
      eop_ok   = 1'b0;
      unique case (state_q)
         IDLE, FINAL: begin
            state_d = IDLE;
            if (fft_valid && fft_sop) begin
               if (fft_eop) begin
                  drop_inc = 1'b1;
               end else begin
                  take    = 1'b1;
                  first   = 1'b1;
                  bin     = '0;
                  k_d     = '0;
                  state_d = ACCUM;
               end
            end
         end
         ACCUM: begin
            if (fft_valid) begin
               if (fft_sop) begin
                  // Restart: the old frame is lost, the sop beat is the new bin 0.
                  drop_inc = 1'b1;
                  if (fft_eop) begin
                     state_d = IDLE;
                  end else begin
                     take  = 1'b1;
                     first = 1'b1;
                     bin   = '0;
                     k_d   = '0;
                  end
               end else begin
                  bin = k_q + K_W'(1);
                  k_d = bin;
                  if (fft_eop) begin
                     if (bin == LAST_BIN) begin
                        take    = 1'b1;
                        eop_ok  = 1'b1;
                        state_d = FINAL;
                     end else begin
                        drop_inc = 1'b1;
                        state_d  = IDLE;
                     end
                  end else if (bin == LAST_BIN) begin
                     drop_inc = 1'b1;
                     state_d  = IDLE;
                  end else begin
                     take = 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
      band = 4'(bin >> BPB_LOG);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         k_q     <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         if (drop_inc && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
      end
   end

   // Stage 1: magnitude plus the sideband that travels with it
   logic [MAG_W-1:0] mag;
   logic             s1_vld_q, s1_first_q, good1_q, good2_q;
   logic [3:0]       s1_band_q;

   fft_mag_abs #(
      .DATA_W (DATA_W)
   ) u_mag (
      .clk    (clk),
      .reset  (reset),
      .en_i   (take),
      .zero_i ((SKIP_DC != 0) && (bin == '0)),
      .re_i   (fft_real),
      .im_i   (fft_imag),
      .mag_o  (mag)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_vld_q   <= 1'b0;
         s1_first_q <= 1'b0;
         s1_band_q  <= '0;
         good1_q    <= 1'b0;
         good2_q    <= 1'b0;
      end else begin
         s1_vld_q   <= take && (bin < HALF_BIN);
         s1_first_q <= first;
         s1_band_q  <= band;
         good1_q    <= eop_ok;
         good2_q    <= good1_q;
      end
   end

   // Stage 2: the first beat of a frame clears every band before accumulating
   logic [ACC_W-1:0] acc_q [NUM_BANDS];

   always_ff @(posedge clk) begin
      for (int unsigned b = 0; b < NUM_BANDS; b++) begin
         if (reset) begin
            acc_q[b] <= '0;
         end else if (s1_vld_q) begin
            if (s1_band_q == 4'(b)) begin
               acc_q[b] <= (s1_first_q ? ACC_ZERO : acc_q[b]) + ACC_W'(mag);
            end else if (s1_first_q) begin
               acc_q[b] <= '0;
            end
         end
      end
   end

   // Publish: scale, saturate and pack every band
   logic [ACC_W-1:0] scaled [NUM_BANDS];
   logic [9:0]       height [NUM_BANDS];
   band_word_t       word_d [NUM_BANDS];
   band_word_t       word_q [NUM_BANDS];
   logic [DEC_W-1:0] dec_q;
   logic             publish, done_q;

   always_comb begin
      for (int unsigned b = 0; b < NUM_BANDS; b++) begin
         scaled[b] = acc_q[b] >> HEIGHT_SHIFT;
         height[b] = (scaled[b] > ACC_W'(MAX_HEIGHT)) ? 10'(MAX_HEIGHT) : scaled[b][9:0];
         word_d[b] = pack_band_word(height[b], 18'(acc_q[b]));
      end
      publish = good2_q && (dec_q == DEC_W'(FRAME_DECIM - 1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dec_q  <= '0;
         done_q <= 1'b0;
         for (int unsigned b = 0; b < NUM_BANDS; b++) word_q[b] <= '0;
      end else begin
         done_q <= publish;
         if (good2_q) dec_q <= publish ? '0 : dec_q + DEC_W'(1);
         if (publish) word_q <= word_d;
      end
   end

   assign processed_fft_data = word_q;
   assign done               = done_q;
   assign drop_count         = drop_q;

endmodule

// File: tb/tb_fft_band_packer.sv
// Randomized self-checking bench for fft_band_packer against a band-sum reference model.
module tb_fft_band_packer;

   localparam int FFT_LEN = 256;
   localparam int SKIP_DC = 1;

   logic               clk = 1'b0;
   logic               reset, fft_valid, fft_sop, fft_eop;
   logic signed [17:0] fft_real, fft_imag;
   logic [35:0]        pfd1 [16];
   logic [35:0]        pfd2 [16];
   logic               done1, done2;
   logic [7:0]         drop1, drop2;

   always #5 clk = ~clk;

   fft_band_packer dut1 (
      .clk                (clk),
      .reset              (reset),
      .fft_valid          (fft_valid),
      .fft_sop            (fft_sop),
      .fft_eop            (fft_eop),
      .fft_real           (fft_real),
      .fft_imag           (fft_imag),
      .processed_fft_data (pfd1),
      .done               (done1),
      .drop_count         (drop1)
   );

   fft_band_packer #(.FRAME_DECIM(2)) dut2 (
      .clk                (clk),
      .reset              (reset),
      .fft_valid          (fft_valid),
      .fft_sop            (fft_sop),
      .fft_eop            (fft_eop),
      .fft_real           (fft_real),
      .fft_imag           (fft_imag),
      .processed_fft_data (pfd2),
      .done               (done2),
      .drop_count         (drop2)
   );

   int cyc = 0;
   int n_checks = 0, n_fail = 0;
   int done1_cnt = 0, done2_cnt = 0, done1_cyc = 0, consec = 0;
   logic prev1 = 1'b0, prev2 = 1'b0;
   int eop_cyc = 0;

   int fr_re [FFT_LEN];
   int fr_im [FFT_LEN];
   logic [35:0] calc [16];
   logic [35:0] exp1 [16];
   logic [35:0] exp2 [16];
   int exp_done1 = 0, exp_done2 = 0, exp_drop = 0, g2 = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done1) begin
         done1_cnt <= done1_cnt + 1;
         done1_cyc <= cyc;
      end
      if (done2) done2_cnt <= done2_cnt + 1;
      if ((done1 && prev1) || (done2 && prev2)) consec <= consec + 1;
      prev1 <= done1;
      prev2 <= done2;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Reference: sum |re|+|im| of the lower half-spectrum into 16 equal bands.
   task automatic model_calc();
      int sums [16];
      int h;
      for (int b = 0; b < 16; b++) sums[b] = 0;
      for (int k = 0; k < FFT_LEN / 2; k++) begin
         if (!(k == 0 && SKIP_DC != 0)) sums[k / (FFT_LEN / 32)] += iabs(fr_re[k]) + iabs(fr_im[k]);
      end
      for (int b = 0; b < 16; b++) begin
         h = sums[b] / 16;
         if (h > 480) h = 480;
         calc[b] = {8'd0, 10'(h), 18'(sums[b])};
      end
   endtask

   task automatic expect_good();
      model_calc();
      exp1 = calc;
      exp_done1++;
      g2++;
      if (g2 == 2) begin
         exp2 = calc;
         exp_done2++;
         g2 = 0;
      end
   endtask

   task automatic expect_reset();
      for (int b = 0; b < 16; b++) begin
         exp1[b] = '0;
         exp2[b] = '0;
      end
      exp_drop = 0;
      g2 = 0;
   endtask

   task automatic fill_const(input int re, input int im);
      for (int k = 0; k < FFT_LEN; k++) begin
         fr_re[k] = re;
         fr_im[k] = im;
      end
   endtask

   task automatic fill_rand();
      logic [17:0] r;
      for (int k = 0; k < FFT_LEN; k++) begin
         r = 18'($urandom);
         fr_re[k] = $signed(r);
         r = 18'($urandom);
         fr_im[k] = $signed(r);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         fft_valid = 1'b0;
         fft_sop   = 1'($urandom);
         fft_eop   = 1'($urandom);
         fft_real  = 18'($urandom);
         fft_imag  = 18'($urandom);
      end
   endtask

   task automatic send_beats(input int n, input bit with_eop, input int gap_pct);
      for (int k = 0; k < n; k++) begin
         if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 3));
         @(negedge clk);
         fft_valid = 1'b1;
         fft_sop   = (k == 0);
         fft_eop   = with_eop && (k == n - 1);
         fft_real  = fr_re[k][17:0];
         fft_imag  = fr_im[k][17:0];
         if (fft_eop) eop_cyc = cyc;
      end
      idle(8);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b1;
      fft_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      expect_reset();
   endtask

   task automatic check_all(input string tag);
      for (int b = 0; b < 16; b++) begin
         check_val($sformatf("%s_d1_band%0d", tag, b), pfd1[b], exp1[b]);
         check_val($sformatf("%s_d2_band%0d", tag, b), pfd2[b], exp2[b]);
      end
      check_val({tag, "_drop1"}, drop1, exp_drop);
      check_val({tag, "_drop2"}, drop2, exp_drop);
      check_val({tag, "_done1_cnt"}, done1_cnt, exp_done1);
      check_val({tag, "_done2_cnt"}, done2_cnt, exp_done2);
      check_val({tag, "_done_consec"}, consec, 0);
   endtask

   initial begin
      reset = 1'b1;
      fft_valid = 1'b0; fft_sop = 1'b0; fft_eop = 1'b0;
      fft_real = '0; fft_imag = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      expect_reset();
      check_all("reset");
      check_val("reset_done1", done1, 0);

      // Flat spectrum, contiguous beats
      fill_const(1000, 0);
      send_beats(FFT_LEN, 1'b1, 0);
      expect_good();
      check_all("flat");
      check_val("flat_latency", done1_cyc - eop_cyc, 3);
      check_val("flat_band0", pfd1[0], {8'd0, 10'd437, 18'd7000});
      check_val("flat_band1", pfd1[1], {8'd0, 10'd480, 18'd8000});
      check_val("flat_band15", pfd1[15], {8'd0, 10'd480, 18'd8000});

      // Single tone with valid gaps
      fill_const(0, 0);
      fr_re[17] = -3200;
      fr_im[17] = 1600;
      send_beats(FFT_LEN, 1'b1, 30);
      expect_good();
      check_all("tone");
      check_val("tone_latency", done1_cyc - eop_cyc, 3);
      check_val("tone_band2", pfd1[2], {8'd0, 10'd300, 18'd4800});
      check_val("tone_d2_band2", pfd2[2], {8'd0, 10'd300, 18'd4800});

      // Early eop at beat 100
      fill_rand();
      send_beats(101, 1'b1, 10);
      exp_drop++;
      check_all("early_eop");

      fill_rand();
      send_beats(FFT_LEN, 1'b1, 20);
      expect_good();
      check_all("after_drop");
      check_val("after_drop_latency", done1_cyc - eop_cyc, 3);

      // sop reasserted at beat 60
      fill_rand();
      send_beats(60, 1'b0, 10);
      exp_drop++;
      fill_rand();
      send_beats(FFT_LEN, 1'b1, 10);
      expect_good();
      check_all("restart");

      // Frame runs to the last bin without eop
      fill_rand();
      send_beats(FFT_LEN, 1'b0, 5);
      exp_drop++;
      check_all("no_eop");

      // Reset mid-frame at beat 80
      fill_rand();
      send_beats(80, 1'b0, 0);
      do_reset();
      check_all("mid_reset");
      fill_rand();
      send_beats(FFT_LEN, 1'b1, 15);
      expect_good();
      check_all("post_reset");

      // Decimation by two over four distinct frames
      do_reset();
      for (int f = 1; f <= 4; f++) begin
         fill_rand();
         if (f == 2) begin
            fr_re[40] = -131072;
            fr_im[40] = -131072;
         end
         send_beats(FFT_LEN, 1'b1, 10);
         expect_good();
         check_all($sformatf("decim_f%0d", f));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
